// File: rtl/rgen_host_arbiter.sv
// Round-robin arbiter that lets HOSTS requesters share one register block command bus.
// Only one command is outstanding at a time, and its completion is routed back to the granted requester.
module rgen_host_arbiter #(
   parameter int HOSTS         = 2,
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32,
   localparam int PW           = (HOSTS > 1) ? $clog2(HOSTS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [HOSTS-1:0]               i_command_valid,
   input  logic [HOSTS-1:0]               i_write,
   input  logic [HOSTS-1:0]               i_read,
   input  logic [HOSTS*ADDRESS_WIDTH-1:0] i_address,
   input  logic [HOSTS*DATA_WIDTH-1:0]    i_write_data,
   input  logic [HOSTS*DATA_WIDTH-1:0]    i_write_mask,
   output logic [HOSTS-1:0]               o_response_ready,
   output logic [DATA_WIDTH-1:0]          o_read_data,
   output logic [2:0]                     o_status,
   output logic                           o_command_valid,
   output logic                           o_write,
   output logic                           o_read,
   output logic [ADDRESS_WIDTH-1:0]       o_address,
   output logic [DATA_WIDTH-1:0]          o_write_data,
   output logic [DATA_WIDTH-1:0]          o_write_mask,
   input  logic                           i_response_ready,
   input  logic [DATA_WIDTH-1:0]          i_read_data,
   input  logic [2:0]                     i_status,
   output logic                           o_debug_state,
   output logic [PW-1:0]                  o_debug_pointer
);

   // Handshake: a requester holds i_command_valid and its command until its
   // o_response_ready pulse. Downstream, o_command_valid stays high with stable
   // command fields until i_response_ready is seen for one cycle.

   localparam int SW = PW + 1;
   localparam logic [PW:0]   HOSTS_W   = HOSTS[PW:0];
   localparam logic [PW-1:0] LAST_HOST = PW'(HOSTS - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [PW-1:0]            pointer_q, pointer_d;
   logic [PW-1:0]            grant_q, grant_d;
   logic                     command_valid_q, command_valid_d;
   logic                     write_q, write_d;
   logic                     read_q, read_d;
   logic [ADDRESS_WIDTH-1:0] address_q, address_d;
   logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
   logic [DATA_WIDTH-1:0]    write_mask_q, write_mask_d;

   logic                     found;
   logic [PW-1:0]            sel;
   logic [PW:0]              cand;
   logic                     sel_write, sel_read;
   logic [ADDRESS_WIDTH-1:0] sel_address;
   logic [DATA_WIDTH-1:0]    sel_write_data, sel_write_mask;

   // Walk candidates pointer, pointer+1, ... (mod HOSTS); the first active one wins.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int j = 0; j < HOSTS; j++) begin
         cand = {1'b0, pointer_q} + SW'(j);
         if (cand >= HOSTS_W) begin
            cand = cand - HOSTS_W;
         end
         for (int k = 0; k < HOSTS; k++) begin
            if (!found && (cand == SW'(k)) && i_command_valid[k]) begin
               found = 1'b1;
               sel   = PW'(k);
            end
         end
      end
   end

   always_comb begin
      sel_write      = 1'b0;
      sel_read       = 1'b0;
      sel_address    = '0;
      sel_write_data = '0;
      sel_write_mask = '0;
      for (int k = 0; k < HOSTS; k++) begin
         if (sel == PW'(k)) begin
            sel_write      = i_write[k];
            sel_read       = i_read[k];
            sel_address    = i_address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            sel_write_data = i_write_data[k*DATA_WIDTH +: DATA_WIDTH];
            sel_write_mask = i_write_mask[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      pointer_d       = pointer_q;
      grant_d         = grant_q;
      command_valid_d = command_valid_q;
      write_d         = write_q;
      read_d          = read_q;
      address_d       = address_q;
      write_data_d    = write_data_q;
      write_mask_d    = write_mask_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d         = ST_BUSY;
               grant_d         = sel;
               command_valid_d = 1'b1;
               write_d         = sel_write;
               read_d          = sel_read;
               address_d       = sel_address;
               write_data_d    = sel_write_data;
               write_mask_d    = sel_write_mask;
            end
         end
         ST_BUSY: begin
            // Requester inputs are ignored here; only the completion pulse matters.
            if (i_response_ready) begin
               state_d         = ST_IDLE;
               command_valid_d = 1'b0;
               write_d         = 1'b0;
               read_d          = 1'b0;
               pointer_d       = (grant_q == LAST_HOST) ? '0 : grant_q + PW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         pointer_q       <= '0;
         grant_q         <= '0;
         command_valid_q <= 1'b0;
         write_q         <= 1'b0;
         read_q          <= 1'b0;
         address_q       <= '0;
         write_data_q    <= '0;
         write_mask_q    <= '0;
      end else begin
         state_q         <= state_d;
         pointer_q       <= pointer_d;
         grant_q         <= grant_d;
         command_valid_q <= command_valid_d;
         write_q         <= write_d;
         read_q          <= read_d;
         address_q       <= address_d;
         write_data_q    <= write_data_d;
         write_mask_q    <= write_mask_d;
      end
   end

   // A completion seen while idle has no owner and is dropped.
   always_comb begin
      o_response_ready = '0;
      for (int k = 0; k < HOSTS; k++) begin
         o_response_ready[k] = (state_q == ST_BUSY) && i_response_ready && (grant_q == PW'(k));
      end
   end

   assign o_read_data     = i_read_data;
   assign o_status        = i_status;
   assign o_command_valid = command_valid_q;
   assign o_write         = write_q;
   assign o_read          = read_q;
   assign o_address       = address_q;
   assign o_write_data    = write_data_q;
   assign o_write_mask    = write_mask_q;
   assign o_debug_state   = (state_q == ST_BUSY);
   assign o_debug_pointer = pointer_q;

endmodule

// File: tb/tb_rgen_host_arbiter.sv
// Bench for rgen_host_arbiter: a two-host and a three-host instance driven by directed vectors,
// with command and response expectations queued by the drivers and popped by per-instance monitors.
module tb_rgen_host_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int CW = 2 + AW + 2 * DW;
   localparam int RW = 3 + DW + 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- two-host instance ----------------
   logic            a_rst_n;
   logic [1:0]      a_cv, a_wr, a_rd, a_rr;
   logic [2*AW-1:0] a_addr;
   logic [2*DW-1:0] a_wd, a_wm;
   logic [DW-1:0]   a_ord, a_owd, a_owm, a_ird;
   logic [2:0]      a_ost, a_ist;
   logic            a_ocv, a_ow, a_or, a_irr, a_dbg_state;
   logic [AW-1:0]   a_oa;
   logic [0:0]      a_dbg_ptr;

   rgen_host_arbiter #(.HOSTS(2), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut_a (
      .clk(clk), .rst_n(a_rst_n),
      .i_command_valid(a_cv), .i_write(a_wr), .i_read(a_rd),
      .i_address(a_addr), .i_write_data(a_wd), .i_write_mask(a_wm),
      .o_response_ready(a_rr), .o_read_data(a_ord), .o_status(a_ost),
      .o_command_valid(a_ocv), .o_write(a_ow), .o_read(a_or),
      .o_address(a_oa), .o_write_data(a_owd), .o_write_mask(a_owm),
      .i_response_ready(a_irr), .i_read_data(a_ird), .i_status(a_ist),
      .o_debug_state(a_dbg_state), .o_debug_pointer(a_dbg_ptr)
   );

   // ---------------- three-host instance ----------------
   logic            b_rst_n;
   logic [2:0]      b_cv, b_wr, b_rd, b_rr;
   logic [3*AW-1:0] b_addr;
   logic [3*DW-1:0] b_wd, b_wm;
   logic [DW-1:0]   b_ord, b_owd, b_owm, b_ird;
   logic [2:0]      b_ost, b_ist;
   logic            b_ocv, b_ow, b_or, b_irr, b_dbg_state;
   logic [AW-1:0]   b_oa;
   logic [1:0]      b_dbg_ptr;

   rgen_host_arbiter #(.HOSTS(3), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut_b (
      .clk(clk), .rst_n(b_rst_n),
      .i_command_valid(b_cv), .i_write(b_wr), .i_read(b_rd),
      .i_address(b_addr), .i_write_data(b_wd), .i_write_mask(b_wm),
      .o_response_ready(b_rr), .o_read_data(b_ord), .o_status(b_ost),
      .o_command_valid(b_ocv), .o_write(b_ow), .o_read(b_or),
      .o_address(b_oa), .o_write_data(b_owd), .o_write_mask(b_owm),
      .i_response_ready(b_irr), .i_read_data(b_ird), .i_status(b_ist),
      .o_debug_state(b_dbg_state), .o_debug_pointer(b_dbg_ptr)
   );

   // ---------------- scoreboard queues ----------------
   logic [CW-1:0] a_cmd_q[$];
   logic [RW-1:0] a_rsp_q[$];
   logic [CW-1:0] b_cmd_q[$];
   logic [RW-1:0] b_rsp_q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitors ----------------
   logic [CW-1:0] a_cur, b_cur;
   logic [RW-1:0] a_rexp, b_rexp;
   logic          a_prev_cv = 1'b0;
   logic          b_prev_cv = 1'b0;

   always @(negedge clk) begin
      if (a_rst_n) begin
         if (a_ocv && !a_prev_cv) begin
            if (a_cmd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_cmd_unexpected actual=%0h required=none", a_oa);
            end else begin
               a_cur = a_cmd_q.pop_front();
               chk("a_cmd", {a_ow, a_or, a_oa, a_owd, a_owm}, a_cur);
            end
         end else if (a_ocv) begin
            chk("a_cmd_hold", {a_ow, a_or, a_oa, a_owd, a_owm}, a_cur);
         end
         if (a_rr != 2'b00) begin
            if (a_rsp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_rsp_unexpected actual=%0b required=none", a_rr);
            end else begin
               a_rexp = a_rsp_q.pop_front();
               chk("a_rsp", {1'b0, a_rr, a_ord, a_ost}, a_rexp);
            end
         end
      end
      a_prev_cv = a_ocv;
   end

   always @(negedge clk) begin
      if (b_rst_n) begin
         if (b_ocv && !b_prev_cv) begin
            if (b_cmd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_cmd_unexpected actual=%0h required=none", b_oa);
            end else begin
               b_cur = b_cmd_q.pop_front();
               chk("b_cmd", {b_ow, b_or, b_oa, b_owd, b_owm}, b_cur);
            end
         end else if (b_ocv) begin
            chk("b_cmd_hold", {b_ow, b_or, b_oa, b_owd, b_owm}, b_cur);
         end
         if (b_rr != 3'b000) begin
            if (b_rsp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_rsp_unexpected actual=%0b required=none", b_rr);
            end else begin
               b_rexp = b_rsp_q.pop_front();
               chk("b_rsp", {b_rr, b_ord, b_ost}, b_rexp);
            end
         end
      end
      b_prev_cv = b_ocv;
   end

   // ---------------- driver tasks ----------------
   task automatic a_set(input int h, input logic v, input logic wr, input logic rd,
                        input logic [AW-1:0] ad, input logic [DW-1:0] wd, input logic [DW-1:0] wm);
      a_cv[h] = v; a_wr[h] = wr; a_rd[h] = rd;
      a_addr[h*AW +: AW] = ad; a_wd[h*DW +: DW] = wd; a_wm[h*DW +: DW] = wm;
   endtask

   task automatic a_expect(input logic wr, input logic rd, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd, input logic [DW-1:0] wm);
      a_cmd_q.push_back({wr, rd, ad, wd, wm});
   endtask

   task automatic a_respond(input logic [DW-1:0] rdat, input logic [2:0] st, input logic [1:0] oh);
      a_rsp_q.push_back({1'b0, oh, rdat, st});
      a_irr = 1'b1; a_ird = rdat; a_ist = st;
      tick();
      a_irr = 1'b0;
   endtask

   task automatic b_set(input int h, input logic v, input logic wr, input logic rd,
                        input logic [AW-1:0] ad, input logic [DW-1:0] wd, input logic [DW-1:0] wm);
      b_cv[h] = v; b_wr[h] = wr; b_rd[h] = rd;
      b_addr[h*AW +: AW] = ad; b_wd[h*DW +: DW] = wd; b_wm[h*DW +: DW] = wm;
   endtask

   task automatic b_respond(input logic [DW-1:0] rdat, input logic [2:0] st, input logic [2:0] oh);
      b_rsp_q.push_back({oh, rdat, st});
      b_irr = 1'b1; b_ird = rdat; b_ist = st;
      tick();
      b_irr = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   logic [2:0] oh3;
   int         k;

   initial begin
      a_rst_n = 1'b0; a_cv = '0; a_wr = '0; a_rd = '0; a_addr = '0; a_wd = '0; a_wm = '0;
      a_irr = 1'b0; a_ird = '0; a_ist = '0;
      b_rst_n = 1'b0; b_cv = '0; b_wr = '0; b_rd = '0; b_addr = '0; b_wd = '0; b_wm = '0;
      b_irr = 1'b0; b_ird = '0; b_ist = '0;
      tick(); tick();

      // reset state
      chk("rst_cv", a_ocv, 1'b0);
      chk("rst_wr_rd", {a_ow, a_or}, 2'b00);
      chk("rst_addr", a_oa, 8'h00);
      chk("rst_wdata", a_owd, 32'h0);
      chk("rst_wmask", a_owm, 32'h0);
      chk("rst_state", a_dbg_state, 1'b0);
      chk("rst_ptr", a_dbg_ptr, 1'b0);
      chk("rst_rr", a_rr, 2'b00);
      a_rst_n = 1'b1;
      tick();

      // single write from host0
      a_expect(1'b1, 1'b0, 8'h04, 32'hDEADBEEF, 32'hFFFFFFFF);
      a_set(0, 1'b1, 1'b1, 1'b0, 8'h04, 32'hDEADBEEF, 32'hFFFFFFFF);
      chk("t1_cv_before", a_ocv, 1'b0);
      tick();
      chk("t1_cv_latency", a_ocv, 1'b1);
      tick();
      a_respond(32'h0, 3'b000, 2'b01);
      a_set(0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      chk("t1_cv_after", a_ocv, 1'b0);
      chk("t1_wr_after", {a_ow, a_or}, 2'b00);
      chk("t1_ptr_after", a_dbg_ptr, 1'b1);
      tick();

      // simultaneous requests after reset: host0 then host1, then host0 again
      a_rst_n = 1'b0; tick(); a_rst_n = 1'b1; tick();
      a_expect(1'b1, 1'b0, 8'h10, 32'h0000_0010, 32'h0000_FFFF);
      a_expect(1'b0, 1'b1, 8'h20, 32'h0000_0020, 32'hFFFF_0000);
      a_set(0, 1'b1, 1'b1, 1'b0, 8'h10, 32'h0000_0010, 32'h0000_FFFF);
      a_set(1, 1'b1, 1'b0, 1'b1, 8'h20, 32'h0000_0020, 32'hFFFF_0000);
      tick(); tick();
      a_respond(32'h1111_0000, 3'b000, 2'b01);
      a_set(0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      tick(); tick();
      a_respond(32'h2222_0000, 3'b001, 2'b10);
      a_set(1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      a_expect(1'b1, 1'b0, 8'h14, 32'hCAFE_0001, 32'h00FF_00FF);
      a_expect(1'b1, 1'b0, 8'h24, 32'hCAFE_0002, 32'hFF00_FF00);
      a_set(0, 1'b1, 1'b1, 1'b0, 8'h14, 32'hCAFE_0001, 32'h00FF_00FF);
      a_set(1, 1'b1, 1'b1, 1'b0, 8'h24, 32'hCAFE_0002, 32'hFF00_FF00);
      tick(); tick();
      a_respond(32'h3333_0000, 3'b000, 2'b01);
      a_set(0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      tick(); tick();
      a_respond(32'h4444_0000, 3'b000, 2'b10);
      a_set(1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      tick();

      // host1 read with data and status routed back
      a_expect(1'b0, 1'b1, 8'h0C, 32'h0, 32'h0);
      a_set(1, 1'b1, 1'b0, 1'b1, 8'h0C, 32'h0, 32'h0);
      tick(); tick();
      a_respond(32'h12345678, 3'b010, 2'b10);
      a_set(1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      tick();

      // requester changes its address while busy; latched command must hold
      a_expect(1'b1, 1'b0, 8'h08, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
      a_set(0, 1'b1, 1'b1, 1'b0, 8'h08, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
      tick();
      a_set(0, 1'b1, 1'b0, 1'b1, 8'h10, 32'h5A5A_5A5A, 32'h0000_0000);
      tick(); tick(); tick();
      chk("t5_addr_held", a_oa, 8'h08);
      a_respond(32'h0, 3'b000, 2'b01);
      a_set(0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      tick();

      // reset mid-busy abandons the command; stray completion is dropped
      a_expect(1'b1, 1'b0, 8'h30, 32'h0000_0055, 32'h0000_00FF);
      a_set(1, 1'b1, 1'b1, 1'b0, 8'h30, 32'h0000_0055, 32'h0000_00FF);
      tick(); tick();
      a_rst_n = 1'b0;
      a_set(1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      tick();
      chk("t6_cv", a_ocv, 1'b0);
      chk("t6_wr", a_ow, 1'b0);
      chk("t6_addr", a_oa, 8'h00);
      chk("t6_state", a_dbg_state, 1'b0);
      chk("t6_ptr", a_dbg_ptr, 1'b0);
      a_rst_n = 1'b1;
      a_irr = 1'b1; a_ird = 32'hBAD0_BAD0; a_ist = 3'b111;
      @(negedge clk);
      chk("t6_stray_rr", a_rr, 2'b00);
      tick();
      a_irr = 1'b0;
      a_expect(1'b1, 1'b0, 8'h50, 32'h0000_0050, 32'hFFFF_FFFF);
      a_expect(1'b1, 1'b0, 8'h60, 32'h0000_0060, 32'hFFFF_FFFF);
      a_set(0, 1'b1, 1'b1, 1'b0, 8'h50, 32'h0000_0050, 32'hFFFF_FFFF);
      a_set(1, 1'b1, 1'b1, 1'b0, 8'h60, 32'h0000_0060, 32'hFFFF_FFFF);
      tick(); tick();
      a_respond(32'h0, 3'b000, 2'b01);
      a_set(0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      tick(); tick();
      a_respond(32'h0, 3'b000, 2'b10);
      a_set(1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      tick();

      // three hosts requesting continuously: grants rotate 0,1,2,0,1
      tick();
      b_rst_n = 1'b1;
      tick();
      chk("b_rst_cv", b_ocv, 1'b0);
      chk("b_rst_ptr", b_dbg_ptr, 2'b00);
      for (int h = 0; h < 3; h++) begin
         b_set(h, 1'b1, 1'b1, 1'b0, 8'h40 + 8'(h), 32'hA000_0000 + 32'(h), 32'hFFFF_FFFF);
      end
      for (int n = 0; n < 5; n++) begin
         k = n % 3;
         b_cmd_q.push_back({1'b1, 1'b0, 8'h40 + 8'(k), 32'hA000_0000 + 32'(k), 32'hFFFF_FFFF});
      end
      for (int n = 0; n < 5; n++) begin
         k = n % 3;
         oh3 = 3'b001 << k;
         tick(); tick();
         b_respond(32'h0000_00B0 + 32'(n), 3'(n), oh3);
      end
      b_cv = '0;
      tick(); tick();
      chk("b_cv_end", b_ocv, 1'b0);
      chk("b_ptr_end", b_dbg_ptr, 2'b10);

      chk("a_cmd_q_empty", a_cmd_q.size(), 0);
      chk("a_rsp_q_empty", a_rsp_q.size(), 0);
      chk("b_cmd_q_empty", b_cmd_q.size(), 0);
      chk("b_rsp_q_empty", b_rsp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
